// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - chunked add/sub sequencer around an external ripple-carry adder
module rca_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    input  logic             req_ci,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_co,
    output logic             rsp_ovf,
    output logic             busy,
    output logic [CHUNK-1:0] add_x,
    output logic [CHUNK-1:0] add_y,
    output logic             add_ci,
    input  logic [CHUNK-1:0] add_s,
    input  logic             add_co
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_beff;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_ovf;

    logic             w_run;
    logic             w_last;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == IW'(NCHUNK - 1));

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_sum   = r_sum;
    assign rsp_co    = r_co;
    assign rsp_ovf   = r_ovf;

    // Adder inputs are forced to zero whenever no chunk is in flight.
    assign add_x  = w_run ? r_a[r_idx*CHUNK +: CHUNK]    : '0;
    assign add_y  = w_run ? r_beff[r_idx*CHUNK +: CHUNK] : '0;
    assign add_ci = w_run ? r_carry : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_beff  <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_beff  <= req_sub ? ~req_b : req_b;
                        r_carry <= req_sub ? 1'b1 : req_ci;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= add_s;
                    r_carry                     <= add_co;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_co    <= add_co;
                        r_ovf   <= (r_a[WIDTH-1] == r_beff[WIDTH-1]) &&
                                   (add_s[CHUNK-1] != r_a[WIDTH-1]);
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - directed self-checking bench for rca_seq_ctrl
module tb_rca_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_sub;
    logic        req_ci;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic        rsp_co;
    logic        rsp_ovf;
    logic        busy;
    logic [3:0]  add_x;
    logic [3:0]  add_y;
    logic        add_ci;
    logic [3:0]  add_s;
    logic        add_co;

    int n_checks = 0;
    int n_fail   = 0;

    rca_seq_ctrl #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_ci(req_ci),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_ovf(rsp_ovf), .busy(busy),
        .add_x(add_x), .add_y(add_y), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co)
    );

    // External 4-bit ripple-carry adder model
    assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request to completion and returns the response plus latency.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic ci,
                          output logic [15:0] sum, output logic co,
                          output logic ovf, output int lat,
                          output logic [15:0] xseq);
        int guard;
        @(negedge clk);
        req_a = a; req_b = b; req_sub = sub; req_ci = ci; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        xseq = '0;
        while (!rsp_valid && lat < 20) begin
            xseq = {xseq[11:0], add_x};
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
        end
        sum = rsp_sum; co = rsp_co; ovf = rsp_ovf;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, busy, rsp_co, rsp_ovf, add_ci} !== 6'b100000 ||
            rsp_sum !== 16'h0 || add_x !== 4'h0 || add_y !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b sum=%h co=%0b ovf=%0b x=%h y=%h ci=%0b, required 1 0 0 0000 0 0 0 0 0",
                     req_ready, rsp_valid, busy, rsp_sum, rsp_co, rsp_ovf, add_x, add_y, add_ci);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%0b, required 1", req_ready);
        end
    endtask

    task automatic test_add_basic;
        logic [15:0] s, xs; logic co, ov; int lat;
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'h2201 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL add_basic: sum=%h co=%0b ovf=%0b, required 2201 0 0", s, co, ov);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL add_latency: %0d cycles, required 4", lat);
        end
        n_checks++;
        if (xs !== 16'h4321) begin
            n_fail++;
            $display("FAIL add_x_sequence: %h, required 4321", xs);
        end
    endtask

    task automatic test_carry_ripple;
        logic [15:0] s, xs; logic co, ov; int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_ripple: sum=%h co=%0b ovf=%0b, required 0000 1 0", s, co, ov);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] s, xs; logic co, ov; int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL add_overflow: sum=%h co=%0b ovf=%0b, required 8000 0 1", s, co, ov);
        end
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'h0001 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL add_carry_in: sum=%h co=%0b ovf=%0b, required 0001 0 0", s, co, ov);
        end
    endtask

    task automatic test_subtract;
        logic [15:0] s, xs; logic co, ov; int lat;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: sum=%h co=%0b ovf=%0b, required fffe 0 0", s, co, ov);
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_overflow: sum=%h co=%0b ovf=%0b, required 7fff 1 1", s, co, ov);
        end
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_ci_ignored: sum=%h co=%0b ovf=%0b, required fffe 0 0", s, co, ov);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] s, xs; logic co, ov; int lat; int guard; int bad;
        @(negedge clk);
        req_a = 16'h0001; req_b = 16'h0002; req_sub = 1'b0; req_ci = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 16'h0010; req_b = 16'h0020;
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_sum !== 16'h0003 ||
                rsp_co !== 1'b0 || rsp_ovf !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stall: %0d unstable cycles (last sum=%h rdy=%0b vld=%0b), required 0 (sum 0003)",
                     bad, rsp_sum, req_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== 16'h0003) begin
            n_fail++;
            $display("FAIL idle_gap: rdy=%0b vld=%0b busy=%0b sum=%h, required 1 0 0 0003",
                     req_ready, rsp_valid, busy, rsp_sum);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL next_accept: busy=%0b rdy=%0b, required 1 0", busy, req_ready);
        end
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0030) begin
            n_fail++;
            $display("FAIL next_result: vld=%0b sum=%h, required 1 0030", rsp_valid, rsp_sum);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] s, xs; logic co, ov; int lat; int seen;
        @(negedge clk);
        req_a = 16'h1111; req_b = 16'h2222; req_sub = 1'b0; req_ci = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (add_x !== 4'h1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_idx2: add_x=%h busy=%0b, required 1 1", add_x, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_sum !== 16'h0 ||
            add_x !== 4'h0 || add_y !== 4'h0 || add_ci !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%0b vld=%0b rdy=%0b sum=%h x=%h y=%h ci=%0b, required 0 0 1 0000 0 0 0",
                     busy, rsp_valid, req_ready, rsp_sum, add_x, add_y, add_ci);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL no_response_after_reset: %0d bad cycles, required 0", seen);
        end
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, s, co, ov, lat, xs);
        n_checks++;
        if (s !== 16'h3333 || co !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL post_reset_op: sum=%h co=%0b ovf=%0b lat=%0d, required 3333 0 0 4", s, co, ov, lat);
        end
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_sub = 1'b0; req_ci = 1'b0; rsp_ready = 1'b0;
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
